fifo_tx_drain: RTL and testbench
================================

# fifo_tx_drain

Read-side drain controller for the asynchronous FIFO, in the read-clock domain. Pops one word at a time whenever the FIFO is non-empty and the downstream serial transmitter is idle. Presents each word with a valid strobe and tracks the transmitter's busy level to pace pops at exactly one per frame. Counts completed frames and, optionally, detects a transmitter that never accepts.

## Interface
Parameters:
- DATA_WIDTH, 8, FIFO word / transmitter data width
- TIMEOUT_CYC, 255, cycles in SEND without tx_busy rising before abort (1..255)

Ports:
- CLK  input  1  read-domain clock (same clock as the FIFO read side)
- RST_n  input  1  asynchronous active-low reset
- tx_enable  input  1  level; 1 permits starting a new pop
- rempty  input  1  FIFO empty flag, CLK domain
- rdata  input  DATA_WIDTH  FIFO head word, valid whenever rempty=0
- rinc  output  1  one-cycle FIFO pop strobe
- tx_busy  input  1  transmitter busy level, synchronous to CLK
- tx_data  output  DATA_WIDTH  captured word for transmitter
- tx_valid  output  1  request to transmitter
- drain_cnt  output  16  completed-frame counter
- timeout_err  output  1  one-cycle abort pulse (DRAIN_TIMEOUT_EN only)

## Operation
- States: IDLE, SEND, WAIT_DONE. Reset state IDLE.
- IDLE: when tx_enable=1, rempty=0 and tx_busy=0, at the clock edge:
  - capture tx_data <= rdata
  - set rinc <= 1
  - go to SEND
  - Otherwise hold; rinc=0.
- SEND: tx_valid=1. On tx_busy=1, go to WAIT_DONE; tx_valid drops on that edge.
- WAIT_DONE: wait for tx_busy=0, then increment drain_cnt and go to IDLE.
- rinc is registered, high for exactly one cycle per captured word, never in two consecutive cycles.
- tx_data holds its value from capture until the next capture; it is not cleared on return to IDLE.
- drain_cnt is modulo 2^16; 16'hFFFF + 1 = 16'h0000.
- tx_enable is sampled only in IDLE. Deassertion during SEND/WAIT_DONE does not abort the frame in progress.
- Boundary conditions:
  - rempty=1 in IDLE: no pop, no state change.
  - FIFO becomes empty after a pop: IDLE waits; no spurious rinc.
  - tx_busy already high in IDLE: no pop until it falls.

## Timing
- Reset values: rinc=0, tx_valid=0, tx_data=0, drain_cnt=0, timeout_err=0, state=IDLE.
- Pop-to-request:
  - Edge N: IDLE decision.
  - Cycle N+1: rinc=1, tx_valid=1.
  - Cycle N+2: rinc=0.
- Minimum per-word cycle is 4 clocks: IDLE, SEND, WAIT_DONE with 1-cycle busy, IDLE. This guarantees rempty has updated after the pop before the next IDLE decision.
- Reset mid-frame returns all outputs to reset values immediately. The popped word is discarded, not re-read.

## Configuration
- DRAIN_TIMEOUT_EN defined:
  - An 8-bit counter clears on SEND entry and increments each SEND cycle.
  - When it reaches TIMEOUT_CYC with tx_busy=0, go to IDLE, drop tx_valid, and pulse timeout_err for one cycle.
  - The word is dropped and drain_cnt is not incremented.
  - If tx_busy rises on the same edge the counter hits TIMEOUT_CYC, tx_busy wins: go to WAIT_DONE with no error.
- DRAIN_TIMEOUT_EN undefined: SEND waits indefinitely, no counter logic, and timeout_err is tied 0.

## Test plan
- Reset, rempty=1, tx_enable=1 for 20 cycles -> rinc never 1, tx_valid=0, drain_cnt=0.
- Three words 8'hA5, 8'h3C, 8'hFF in FIFO, transmitter modelled as tx_busy high 10 cycles starting 1 cycle after tx_valid -> tx_data sequence A5, 3C, FF; exactly 3 rinc pulses; drain_cnt=3; final rempty=1.
- tx_busy held high in IDLE with data present -> no rinc until tx_busy falls, then pop in the next cycle.
- tx_enable dropped during WAIT_DONE with 2 words queued -> current frame completes (drain_cnt +1), second word not popped until tx_enable returns.
- DRAIN_TIMEOUT_EN, TIMEOUT_CYC=5, tx_busy stuck 0 -> tx_valid high for 5 cycles, one timeout_err pulse, drain_cnt unchanged, next word popped after return to IDLE.
- Assert RST_n=0 during SEND, hold 2 cycles, release with 1 word queued -> all outputs 0 during reset, next pop pops the following word, drain_cnt counts from 0.

Source files
------------

// File: rtl/fifo_tx_drain.sv
// rtl/fifo_tx_drain.sv - read-side FIFO drain controller pacing one pop per transmitter frame.
// Optional abort of a frame the transmitter never accepts: define DRAIN_TIMEOUT_EN.
module fifo_tx_drain #(
    parameter int DATA_WIDTH  = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic                  tx_enable,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    input  logic                  tx_busy,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    output logic [15:0]           drain_cnt,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND      = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    rinc_q, rinc_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [15:0]             cnt_q, cnt_d;

`ifdef DRAIN_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] to_cnt_q, to_cnt_d;
    logic       to_err_q, to_err_d;
`endif

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q  <= S_IDLE;
            rinc_q   <= 1'b0;
            data_q   <= '0;
            cnt_q    <= '0;
`ifdef DRAIN_TIMEOUT_EN
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rinc_q   <= rinc_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
`ifdef DRAIN_TIMEOUT_EN
            to_cnt_q <= to_cnt_d;
            to_err_q <= to_err_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        rinc_d   = 1'b0;
        data_d   = data_q;
        cnt_d    = cnt_q;
`ifdef DRAIN_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
        to_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // The 4-cycle minimum loop guarantees rempty reflects the last pop here.
                if (tx_enable && !rempty && !tx_busy) begin
                    data_d  = rdata;
                    rinc_d  = 1'b1;
                    state_d = S_SEND;
`ifdef DRAIN_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
            end
            S_SEND: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else begin
`ifdef DRAIN_TIMEOUT_EN
                    // Busy rising wins over a coincident timeout via the branch above.
                    if (to_cnt_q == TO_LAST) begin
                        state_d  = S_IDLE;
                        to_err_d = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + 8'd1;
                    end
`endif
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rinc      = rinc_q;
    assign tx_data   = data_q;
    assign tx_valid  = (state_q == S_SEND);
    assign drain_cnt = cnt_q;
`ifdef DRAIN_TIMEOUT_EN
    assign timeout_err = to_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_tx_drain.sv
// tb/tb_fifo_tx_drain.sv - scoreboard bench for fifo_tx_drain with FIFO and transmitter models.
module tb_fifo_tx_drain;

    logic       CLK = 1'b0;
    logic       RST_n = 1'b0;
    logic       tx_enable = 1'b0;
    logic       rempty = 1'b1;
    logic [7:0] rdata = 8'h00;
    logic       rinc;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [15:0] drain_cnt;
    logic       timeout_err;

    logic       model_busy = 1'b0;
    logic       busy_force = 1'b0;
    logic       tx_auto = 1'b0;

    int checks = 0;
    int failures = 0;
    int rinc_count = 0;
    int valid_cycles = 0;
    int to_count = 0;
    logic rinc_prev = 1'b0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];

    assign tx_busy = model_busy | busy_force;

    always #5 CLK = ~CLK;

    fifo_tx_drain #(.DATA_WIDTH(8), .TIMEOUT_CYC(5)) dut (
        .CLK(CLK), .RST_n(RST_n), .tx_enable(tx_enable), .rempty(rempty),
        .rdata(rdata), .rinc(rinc), .tx_busy(tx_busy), .tx_data(tx_data),
        .tx_valid(tx_valid), .drain_cnt(drain_cnt), .timeout_err(timeout_err)
    );

    // FIFO read side: sole writer of rempty/rdata
    initial begin
        forever begin
            @(negedge CLK);
            if (rinc && fifo_q.size() > 0) void'(fifo_q.pop_front());
            rempty = (fifo_q.size() == 0);
            rdata  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
        end
    end

    // Transmitter: busy for 10 cycles starting one cycle after it sees tx_valid
    initial begin
        forever begin
            @(posedge CLK); #1;
            if (tx_auto && tx_valid && !model_busy) begin
                @(posedge CLK); #1;
                model_busy = 1'b1;
                repeat (10) @(posedge CLK);
                #1 model_busy = 1'b0;
            end
        end
    end

    // Monitor: each pop must present the next expected word one cycle later
    initial begin
        forever begin
            @(negedge CLK);
            if (tx_valid) valid_cycles++;
            if (timeout_err) to_count++;
            if (rinc) begin
                rinc_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL pop_unexpected: tx_data=%h popped with no word expected", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data !== e || tx_valid !== 1'b1) begin
                        failures++;
                        $display("FAIL pop_word: tx_data=%h tx_valid=%b, required %h and 1", tx_data, tx_valid, e);
                    end
                end
                checks++;
                if (rinc_prev) begin
                    failures++;
                    $display("FAIL rinc_back_to_back: rinc=1 in two consecutive cycles, required single pulse");
                end
            end
            rinc_prev = rinc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic wait_cnt(input logic [15:0] target, input string name);
        int n;
        n = 0;
        while (drain_cnt !== target && n < 400) begin
            @(posedge CLK); #1;
            n++;
        end
        if (drain_cnt !== target) begin
            checks++;
            failures++;
            $display("FAIL %s: timeout waiting drain_cnt, got %0h, required %0h", name, drain_cnt, target);
        end
    endtask

    task automatic wait_valid(input logic level, input string name);
        int n;
        n = 0;
        while (tx_valid !== level && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        if (tx_valid !== level) begin
            checks++;
            failures++;
            $display("FAIL %s: timeout waiting tx_valid, got %b, required %b", name, tx_valid, level);
        end
    endtask

    initial begin
        int v0;
        int t0;
        int r0;

        // Reset and empty FIFO
        repeat (3) @(posedge CLK);
        #1;
        check("reset_rinc", 32'(rinc), 32'h0);
        check("reset_tx_valid", 32'(tx_valid), 32'h0);
        check("reset_tx_data", 32'(tx_data), 32'h0);
        check("reset_drain_cnt", 32'(drain_cnt), 32'h0);
        check("reset_timeout_err", 32'(timeout_err), 32'h0);
        RST_n = 1'b1;
        tx_enable = 1'b1;
        v0 = valid_cycles;
        repeat (20) @(posedge CLK);
        #1;
        check("empty_no_rinc", 32'(rinc_count), 32'h0);
        check("empty_no_valid", 32'(valid_cycles - v0), 32'h0);
        check("empty_drain_cnt", 32'(drain_cnt), 32'h0);

        // Three-word drain
        tx_auto = 1'b1;
        push_word(8'hA5);
        push_word(8'h3C);
        push_word(8'hFF);
        wait_cnt(16'd3, "three_words");
        repeat (3) @(posedge CLK);
        #1;
        check("three_rinc_count", 32'(rinc_count), 32'd3);
        check("three_drain_cnt", 32'(drain_cnt), 32'd3);
        check("three_rempty", 32'(rempty), 32'h1);
        check("three_last_data", 32'(tx_data), 32'hFF);
        check("three_exp_drained", 32'(exp_q.size()), 32'h0);

        // Busy already high in IDLE
        busy_force = 1'b1;
        push_word(8'h11);
        repeat (8) @(posedge CLK);
        #1;
        check("busy_hold_no_pop", 32'(rinc_count), 32'd3);
        busy_force = 1'b0;
        @(posedge CLK); #1;
        check("busy_release_pop", 32'(rinc), 32'h1);
        wait_cnt(16'd4, "busy_frame");
        check("busy_drain_cnt", 32'(drain_cnt), 32'd4);

        // tx_enable dropped mid-frame
        repeat (2) @(posedge CLK);
        #1;
        push_word(8'h5A);
        push_word(8'hC3);
        r0 = 0;
        while (!model_busy && r0 < 50) begin
            @(posedge CLK); #1;
            r0++;
        end
        @(posedge CLK); #1;
        tx_enable = 1'b0;
        wait_cnt(16'd5, "enable_drop_complete");
        repeat (15) @(posedge CLK);
        #1;
        check("enable_drop_rinc", 32'(rinc_count), 32'd5);
        check("enable_drop_cnt", 32'(drain_cnt), 32'd5);
        check("enable_drop_fifo", 32'(fifo_q.size()), 32'd1);
        tx_enable = 1'b1;
        wait_cnt(16'd6, "enable_return");
        check("enable_return_rinc", 32'(rinc_count), 32'd6);
        repeat (3) @(posedge CLK);
        #1;

`ifdef DRAIN_TIMEOUT_EN
        // Transmitter stuck idle: abort after 5 SEND cycles
        tx_auto = 1'b0;
        t0 = to_count;
        push_word(8'h77);
        push_word(8'h88);
        wait_valid(1'b1, "timeout_start");
        v0 = valid_cycles;
        wait_valid(1'b0, "timeout_end");
        check("timeout_valid_cycles", 32'(valid_cycles - v0), 32'd5);
        tx_auto = 1'b1;
        wait_cnt(16'd7, "timeout_next_word");
        check("timeout_pulses", 32'(to_count - t0), 32'd1);
        check("timeout_drain_cnt", 32'(drain_cnt), 32'd7);
        check("timeout_next_data", 32'(tx_data), 32'h88);
        repeat (3) @(posedge CLK);
        #1;
`else
        check("timeout_err_never", 32'(to_count), 32'd0);
`endif

        // Reset during SEND
        tx_auto = 1'b0;
        r0 = rinc_count;
        push_word(8'h21);
        push_word(8'h42);
        wait_valid(1'b1, "reset_send_start");
        @(posedge CLK); #1;
        RST_n = 1'b0;
        #1;
        check("midreset_rinc", 32'(rinc), 32'h0);
        check("midreset_tx_valid", 32'(tx_valid), 32'h0);
        check("midreset_tx_data", 32'(tx_data), 32'h0);
        check("midreset_drain_cnt", 32'(drain_cnt), 32'h0);
        check("midreset_timeout_err", 32'(timeout_err), 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        check("midreset_hold_valid", 32'(tx_valid), 32'h0);
        RST_n = 1'b1;
        tx_auto = 1'b1;
        wait_cnt(16'd1, "after_reset_frame");
        check("after_reset_cnt", 32'(drain_cnt), 32'd1);
        check("after_reset_data", 32'(tx_data), 32'h42);
        check("after_reset_pops", 32'(rinc_count - r0), 32'd2);
        check("after_reset_fifo", 32'(fifo_q.size()), 32'd0);
        check("after_reset_exp", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
